dcache_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache in the MEM stage.
- Sits directly upstream of the load-extension stage; supplies the raw aligned 32-bit word, and byte/half selection plus sign extension happen downstream.
- Stores use per-byte enables.
- Stalls the pipeline through `miss` while a line is written back to, or refilled from, the word-serial main-memory port.

---
 rtl/dcache_dm.sv | 121 ++++++++++++
 tb/tb_dcache_dm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-back write-allocate data cache with a word-serial memory port
// Ports: clk, rst (sync, active-high); rd_req/wr_req/addr/wr_data/wr_be request side;
//        rd_data/miss response side, where miss is a combinational pipeline stall;
//        mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack word-serial write-back/refill port.
// Define DCACHE_STATS_EN to add the hit_count/miss_count outputs.
module dcache_dm #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int WORDS = 1 << LINE_ADDR_LEN;
    localparam int SETS = 1 << SET_ADDR_LEN;
    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
    state_t state, nxt;
    logic [31:0] data [SETS][WORDS];
    logic [TAG_LEN-1:0] tags [SETS];
    logic [SETS-1:0] valid, dirty;
    logic [LINE_ADDR_LEN-1:0] cnt, off;
    logic [SET_ADDR_LEN-1:0] set_idx, r_set;
    logic [TAG_LEN-1:0] tag, r_tag, v_tag;
    logic req, hit, lookup_miss, last;
    logic unused_addr;
    assign off = addr[LINE_ADDR_LEN+1:2];
    assign set_idx = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign tag = addr[31:LINE_ADDR_LEN+SET_ADDR_LEN+2];
    assign unused_addr = ^addr[1:0];
    assign req = rd_req | wr_req;
    assign hit = req & valid[set_idx] & (tags[set_idx] == tag);
    assign lookup_miss = req & ~hit;
    assign last = mem_ack & (cnt == '1);
    assign rd_data = data[set_idx][off];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= nxt;
            if (mem_req && mem_ack) cnt <= cnt + 1'b1;
            if (state == SWAP_IN_OK) begin
                valid[r_set] <= 1'b1;
                dirty[r_set] <= 1'b0;
            end
            if (state == IDLE && hit && wr_req && |wr_be) dirty[set_idx] <= 1'b1;
        end
    end
    always_comb begin
        nxt = state;
        miss = 1'b1;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                miss = lookup_miss;
                nxt = !lookup_miss ? IDLE : (valid[set_idx] && dirty[set_idx]) ? SWAP_OUT : SWAP_IN;
            end
            SWAP_OUT: begin
                mem_req = 1'b1;
                mem_we = 1'b1;
                mem_addr = {v_tag, r_set, cnt, 2'b00};
                mem_wdata = data[r_set][cnt];
                nxt = last ? SWAP_IN : SWAP_OUT;
            end
            SWAP_IN: begin
                mem_req = 1'b1;
                mem_addr = {r_tag, r_set, cnt, 2'b00};
                nxt = last ? SWAP_IN_OK : SWAP_IN;
            end
            default: nxt = IDLE;
        endcase
    end
    // Refill words land directly in the target line; it cannot be observed before
    // SWAP_IN_OK because miss holds the pipeline for the whole transfer.
    always_ff @(posedge clk) begin
        if (state == IDLE && lookup_miss) begin
            v_tag <= tags[set_idx];
            r_tag <= tag;
            r_set <= set_idx;
        end
        if (state == SWAP_IN && mem_ack) data[r_set][cnt] <= mem_rdata;
        if (state == SWAP_IN_OK) tags[r_set] <= r_tag;
        if (state == IDLE && hit && wr_req)
            for (int i = 0; i < 4; i++)
                if (wr_be[i]) data[set_idx][off][8*i +: 8] <= wr_data[8*i +: 8];
    end
`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && hit) hit_count <= hit_count + 1;
            if (state == IDLE && lookup_miss) miss_count <= miss_count + 1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: scoreboard bench checking dcache_dm against a transparent-memory reference model
module tb_dcache_dm;
    logic        clk, rst, rd_req, wr_req, miss, mem_req, mem_we, mem_ack;
    logic [31:0] addr, wr_data, rd_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  wr_be;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_dm dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data), .miss(miss),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    typedef struct {
        bit          load;
        logic [31:0] data;
        bit          missed;
        int          n_wr;
        int          n_rd;
        logic [31:0] wb_base;
        logic [31:0] rf_base;
    } exp_t;

    exp_t        q[$];
    int unsigned vectors, miscompares;
    int          ack_pct;
    logic [31:0] backing [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [22:0] m_tag [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bget(logic [31:0] a);
        int unsigned w = a >> 2;
        return backing.exists(w) ? backing[w] : 32'h1000 + w;
    endfunction

    function automatic logic [31:0] rget(logic [31:0] a);
        int unsigned w = a >> 2;
        return ref_mem.exists(w) ? ref_mem[w] : 32'h1000 + w;
    endfunction

    task automatic finish_run();
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Reset empties the cache and throws away dirty lines: the visible memory becomes
    // whatever actually reached the backing store.
    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        ref_mem.delete();
        foreach (backing[k]) ref_mem[k] = backing[k];
    endtask

    task automatic issue(bit rd, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        exp_t e;
        int s = int'(a[8:5]);
        logic [22:0] t = a[31:9];
        bit h = m_valid[s] && m_tag[s] == t;
        logic [31:0] w;
        e.missed = !h;
        e.n_rd = h ? 0 : 8;
        e.n_wr = (!h && m_valid[s] && m_dirty[s]) ? 8 : 0;
        e.wb_base = {m_tag[s], a[8:5], 5'b0};
        e.rf_base = {t, a[8:5], 5'b0};
        if (!h) begin
            m_valid[s] = 1'b1;
            m_tag[s] = t;
            m_dirty[s] = 1'b0;
        end
        if (wr) begin
            w = rget(a);
            for (int i = 0; i < 4; i++)
                if (be[i]) w[8*i +: 8] = d[8*i +: 8];
            ref_mem[a >> 2] = w;
            if (be != 4'b0) m_dirty[s] = 1'b1;
        end
        e.load = rd && !wr;
        e.data = rget(a);
        q.push_back(e);
    endtask

    task automatic access(bit rd, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        int n = 0;
        issue(rd, wr, a, d, be);
        rd_req = rd;
        wr_req = wr;
        addr = a;
        wr_data = d;
        wr_be = be;
        do begin
            @(negedge clk);
            n++;
        end while (miss && n < 2000);
        if (miss) begin
            chk("hold_timeout", miss, 0);
            finish_run();
        end
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = (mem_req === 1'b1) && ($urandom_range(0, 99) < ack_pct);
            mem_rdata = (mem_req === 1'b1) ? bget(mem_addr) : 32'h0;
        end
    end

    initial begin
        exp_t e;
        bit fresh;
        int nw, nr, since;
        fresh = 1'b1;
        nw = 0;
        nr = 0;
        since = 100;
        forever begin
            @(negedge clk);
            if (rst) begin
                fresh = 1'b1;
                nw = 0;
                nr = 0;
                since = 100;
                continue;
            end
            since++;
            if (mem_req && mem_ack) begin
                since = 0;
                if (q.size() == 0) chk("mem_idle_ack", mem_req, 0);
                else if (mem_we) begin
                    chk("wb_addr", mem_addr, q[0].wb_base + 32'(4 * nw));
                    chk("wb_data", mem_wdata, rget(mem_addr));
                    backing[mem_addr >> 2] = mem_wdata;
                    nw++;
                end else begin
                    chk("rf_addr", mem_addr, q[0].rf_base + 32'(4 * nr));
                    nr++;
                end
            end
            if ((rd_req || wr_req) && q.size() > 0) begin
                if (fresh) begin
                    chk("miss_same_cycle", miss, q[0].missed);
                    fresh = 1'b0;
                end
                if (!miss) begin
                    e = q.pop_front();
                    chk("wb_words", nw, e.n_wr);
                    chk("rf_words", nr, e.n_rd);
                    if (e.missed) chk("refill_latency", since, 2);
                    if (e.load) chk("rd_data", rd_data, e.data);
                    fresh = 1'b1;
                    nw = 0;
                    nr = 0;
                end
            end
        end
    end

    initial begin
        int n, acks;
        vectors = 0;
        miscompares = 0;
        ack_pct = 70;
        rst = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        addr = '0;
        wr_data = '0;
        wr_be = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_miss", miss, 0);
        @(posedge clk);
        #1;
        access(1, 0, 32'h10, 0, 0);
        access(0, 1, 32'h14, 32'hAABBCCDD, 4'b0011);
        access(1, 0, 32'h14, 0, 0);
`ifdef DCACHE_STATS_EN
        chk("miss_count", miss_count, 1);
        chk("hit_count", hit_count, 3);
`endif
        access(1, 0, 32'h214, 0, 0);
        access(1, 0, 32'h414, 0, 0);
        access(0, 1, 32'h20, 32'h12345678, 4'hF);
        issue(1, 0, 32'h614, 0, 0);
        rd_req = 1'b1;
        addr = 32'h614;
        n = 0;
        acks = 0;
        while (acks < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (mem_req && mem_ack && !mem_we) acks++;
        end
        if (acks < 3) begin
            chk("ack_wait", acks, 3);
            finish_run();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd_req = 1'b0;
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_miss", miss, 0);
        @(posedge clk);
        #1;
        access(1, 0, 32'h614, 0, 0);
        access(1, 0, 32'h20, 0, 0);
        ack_pct = 50;
        for (int i = 0; i < 300; i++) begin
            int k = int'($urandom_range(0, 9));
            logic [31:0] a = {23'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 2'b00};
            access(k < 5 || k == 9, k >= 5, a, $urandom, 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_miss", miss, 0);
                chk("idle_mem_req", mem_req, 0);
                @(posedge clk);
                #1;
            end
        end
        repeat (2) @(posedge clk);
        finish_run();
    end
endmodule
